coh_bus_arbiter: RTL and testbench

Two-core snooping-bus arbiter and transaction sequencer. It accepts read-miss and write-miss requests from the two cores' data caches and grants the shared bus to one core at a time, using round-robin priority. For the granted transaction it drives the snoop request to the other core's cache and, based on the snoop result, selects whether data comes from memory or from the other processor. It then times the data phase and signals completion. It sits between the two cache controllers and the memory/forwarding datapath mux.

---
 rtl/coh_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_coh_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/coh_bus_arbiter.sv
// Two-core snooping-bus arbiter: round-robin grant, snoop of the other core,
// memory/forward source select and timed data phase ending in a done pulse.
//
// state | meaning
// IDLE  | bus free, arbitrate between req0/req1
// SNOOP | snoop the non-owner, capture its hit as the data source
// DATA  | data phase, counter runs down to zero
// DONE  | done pulse to the owner, update round-robin pointer
module coh_bus_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 4,
  parameter int C2C_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_op,
  output logic              snoop0,
  output logic              snoop1,
  input  logic              hit0,
  input  logic              hit1,
  output logic              inval,
  output logic              src_sel,
  output logic              mem_rd,
  output logic              done0,
  output logic              done1
);

  localparam int MAX_LAT = (MEM_LAT > C2C_LAT) ? MEM_LAT : C2C_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MEM_LD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] C2C_LD = CNT_W'(C2C_LAT - 1);

  typedef enum logic [1:0] {IDLE, SNOOP, DATA, DONE} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             hit_y;

  // On a tie the core that was not served last wins.
  assign pick  = (req0 && req1) ? ~last : req1;
  assign hit_y = owner ? hit0 : hit1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      bus_addr <= '0;
      bus_op   <= 1'b0;
      snoop0   <= 1'b0;
      snoop1   <= 1'b0;
      inval    <= 1'b0;
      src_sel  <= 1'b0;
      mem_rd   <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            gnt0     <= ~pick;
            gnt1     <= pick;
            bus_addr <= pick ? addr1 : addr0;
            bus_op   <= pick ? op1 : op0;
            snoop0   <= pick;
            snoop1   <= ~pick;
            inval    <= pick ? op1 : op0;
            state    <= SNOOP;
          end
        end
        SNOOP: begin
          snoop0  <= 1'b0;
          snoop1  <= 1'b0;
          inval   <= 1'b0;
          src_sel <= hit_y;
          mem_rd  <= ~hit_y;
          cnt     <= hit_y ? C2C_LD : MEM_LD;
          state   <= DATA;
        end
        DATA: begin
          if (cnt == '0) begin
            mem_rd <= 1'b0;
            done0  <= ~owner;
            done1  <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done0    <= 1'b0;
          done1    <= 1'b0;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          bus_addr <= '0;
          bus_op   <= 1'b0;
          src_sel  <= 1'b0;
          last     <= owner;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coh_bus_arbiter.sv
// Directed bench for coh_bus_arbiter: per-cycle expected output vectors
// derived from the request-to-done timeline of each transaction.
module tb_coh_bus_arbiter;

  localparam int MEM_LAT = 4;
  localparam int C2C_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, op0, op1, hit0, hit1;
  logic [4:0] addr0, addr1;
  logic       gnt0, gnt1, bus_op, snoop0, snoop1, inval, src_sel, mem_rd, done0, done1;
  logic [4:0] bus_addr;
  logic [14:0] outs;

  int checks = 0;
  int errors = 0;

  coh_bus_arbiter #(.ADDR_W(5), .MEM_LAT(MEM_LAT), .C2C_LAT(C2C_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .bus_addr(bus_addr), .bus_op(bus_op),
    .snoop0(snoop0), .snoop1(snoop1), .hit0(hit0), .hit1(hit1),
    .inval(inval), .src_sel(src_sel), .mem_rd(mem_rd),
    .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  assign outs = {gnt0, gnt1, bus_addr, bus_op, snoop0, snoop1, inval,
                 src_sel, mem_rd, done0, done1};

  // Expected outputs in cycle c of a transaction whose request was first sampled at edge 0.
  function automatic logic [14:0] exp_vec(input int core, input logic op,
                                          input logic [4:0] addr, input logic src,
                                          input int c);
    int L;
    logic act;
    logic [14:0] v;
    L   = src ? C2C_LAT : MEM_LAT;
    act = (c >= 1) && (c <= 2 + L);
    v = '0;
    v[14]   = act && (core == 0);
    v[13]   = act && (core == 1);
    v[12:8] = act ? addr : 5'h00;
    v[7]    = act && op;
    v[6]    = (c == 1) && (core == 1);
    v[5]    = (c == 1) && (core == 0);
    v[4]    = (c == 1) && op;
    v[3]    = (c >= 2) && (c <= 2 + L) && src;
    v[2]    = (c >= 2) && (c <= 1 + L) && !src;
    v[1]    = (c == 2 + L) && (core == 0);
    v[0]    = (c == 2 + L) && (core == 1);
    return v;
  endfunction

  task test_reset();
    @(negedge clk);
    checks++;
    if (outs !== 15'h0) begin
      errors++;
      $display("FAIL reset_active: got %h expected %h", outs, 15'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 15'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", outs, 15'h0);
    end
  endtask

  task test_read_mem();
    logic [14:0] e;
    req0 = 1'b1; op0 = 1'b0; addr0 = 5'h0A; hit1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e = exp_vec(0, 1'b0, 5'h0A, 1'b0, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL read_mem cycle %0d: got %h expected %h", c, outs, e);
      end
      if (c == 2) begin addr0 = 5'h15; op0 = 1'b1; end
      if (c == 6) req0 = 1'b0;
    end
    op0 = 1'b0;
  endtask

  task test_read_c2c();
    logic [14:0] e;
    req1 = 1'b1; op1 = 1'b0; addr1 = 5'h13; hit0 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e = exp_vec(1, 1'b0, 5'h13, 1'b1, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL read_c2c cycle %0d: got %h expected %h", c, outs, e);
      end
      if (c == 4) req1 = 1'b0;
    end
    hit0 = 1'b0;
  endtask

  task test_write_c2c();
    logic [14:0] e;
    req1 = 1'b1; op1 = 1'b1; addr1 = 5'h07; hit0 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e = exp_vec(1, 1'b1, 5'h07, 1'b1, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL write_c2c cycle %0d: got %h expected %h", c, outs, e);
      end
      if (c == 4) req1 = 1'b0;
    end
    hit0 = 1'b0; op1 = 1'b0;
  endtask

  task test_tie();
    logic [14:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0;
    op0 = 1'b0; op1 = 1'b0; addr0 = 5'h03; addr1 = 5'h1C;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      e = exp_vec(0, 1'b0, 5'h03, 1'b0, c) |
          exp_vec(1, 1'b0, 5'h1C, 1'b0, c - 7) |
          exp_vec(0, 1'b0, 5'h03, 1'b0, c - 14);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL tie cycle %0d: got %h expected %h", c, outs, e);
      end
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL tie_onehot cycle %0d: got gnt0=%b gnt1=%b expected not both", c, gnt0, gnt1);
      end
      if (c == 6)  req0 = 1'b0;
      if (c == 9)  req0 = 1'b1;
      if (c == 20) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task test_reset_mid();
    logic [14:0] e;
    req0 = 1'b1; op0 = 1'b0; addr0 = 5'h09; hit1 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      e = exp_vec(0, 1'b0, 5'h09, 1'b0, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", c, outs, e);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", outs, 15'h0);
    end
    @(negedge clk);
    checks++;
    if (outs !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: got %h expected %h", outs, 15'h0);
    end
    req1 = 1'b1; addr1 = 5'h1C; op1 = 1'b0;
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e = exp_vec(0, 1'b0, 5'h09, 1'b0, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset_mid_tie cycle %0d: got %h expected %h", c, outs, e);
      end
      if (c == 6) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task test_req_drop();
    logic [14:0] e;
    req0 = 1'b1; op0 = 1'b0; addr0 = 5'h11; hit1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e = exp_vec(0, 1'b0, 5'h11, 1'b0, c);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL req_drop cycle %0d: got %h expected %h", c, outs, e);
      end
      if (c == 3) req0 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0; addr0 = 5'h00; addr1 = 5'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_read_mem();
    test_read_c2c();
    test_write_c2c();
    test_tie();
    test_reset_mid();
    test_req_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
